// File: rtl/io_ctrl_pkg.sv
// rtl/io_ctrl_pkg.sv - shared state encoding and data width for the I/O sequencer
package io_ctrl_pkg;

  localparam int DATA_WIDTH = 32;

  typedef logic [1:0] io_state_t;

  localparam io_state_t ST_IDLE         = 2'd0;
  localparam io_state_t ST_WAIT_PRESS   = 2'd1;
  localparam io_state_t ST_WAIT_RELEASE = 2'd2;
  localparam io_state_t ST_DONE         = 2'd3;

endpackage

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - key synchronizer and debouncer producing one-cycle press/release events
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key_n,
  output logic key_press,
  output logic key_release
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          synced;
  logic          key_level;
  logic [CW-1:0] stable_cnt;

  // Synchronizer stores the key in pressed-high polarity.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], ~key_n};
    end
  end

  assign synced = sync_q[1];

  // The counter tracks consecutive samples that disagree with the accepted level.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      key_level   <= 1'b0;
      stable_cnt  <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      if (synced == key_level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == LAST) begin
        stable_cnt  <= '0;
        key_level   <= synced;
        key_press   <= synced;
        key_release <= ~synced;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_input_sequencer.sv
// rtl/io_input_sequencer.sv - IN/OUT sequencer: halts CPU until a debounced key press captures switches
// Optional press timeout in WAIT_PRESS is enabled by defining IO_TIMEOUT_EN.
module io_input_sequencer
  import io_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SW_WIDTH        = 13,
  parameter int TIMEOUT_CYCLES  = 2**24
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  OpIn,
  input  logic                  OpOut,
  input  logic [DATA_WIDTH-1:0] DadosSaida,
  input  logic [SW_WIDTH-1:0]   Switches,
  input  logic                  Set,
  output logic                  HaltCPU,
  output logic [DATA_WIDTH-1:0] DataIO,
  output logic                  DataValid,
  output logic [DATA_WIDTH-1:0] OutputData,
  output logic                  WaitingLed,
  output logic                  TimeoutFlag
);

  io_state_t state;
  io_state_t next_state;
  logic      key_press;
  logic      key_release;
  logic      to_hit;
  logic      capture;

  io_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .Clock      (Clock),
    .Reset      (Reset),
    .key_n      (Set),
    .key_press  (key_press),
    .key_release(key_release)
  );

`ifdef IO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] to_cnt;

  assign to_hit = (state == ST_WAIT_PRESS) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      to_cnt      <= '0;
      TimeoutFlag <= 1'b0;
    end else begin
      to_cnt <= (state == ST_WAIT_PRESS) ? to_cnt + 1'b1 : '0;
      // A real press in the same cycle wins; the flag only marks forced releases.
      if (to_hit && !key_press) begin
        TimeoutFlag <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign to_hit             = 1'b0;
  assign TimeoutFlag        = 1'b0;
`endif

  assign capture = (state == ST_WAIT_PRESS) && (key_press || to_hit);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Press/release are edge events, so a key already held when IN starts never counts as a press.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (OpIn) begin
          next_state = ST_WAIT_PRESS;
        end
      end
      ST_WAIT_PRESS: begin
        if (key_press) begin
          next_state = ST_WAIT_RELEASE;
        end else if (to_hit) begin
          next_state = ST_DONE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (key_release) begin
          next_state = ST_DONE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    HaltCPU    = 1'b0;
    WaitingLed = 1'b0;
    DataValid  = 1'b0;
    case (state)
      ST_WAIT_PRESS: begin
        HaltCPU    = 1'b1;
        WaitingLed = 1'b1;
      end
      ST_WAIT_RELEASE: begin
        HaltCPU = 1'b1;
      end
      ST_DONE: begin
        DataValid = 1'b1;
      end
      default: begin
        HaltCPU = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      DataIO     <= '0;
      OutputData <= '0;
    end else begin
      if (capture) begin
        DataIO <= DATA_WIDTH'(Switches);
      end
      if (OpOut && !HaltCPU) begin
        OutputData <= DadosSaida;
      end
    end
  end

endmodule

// File: tb/tb_io_input_sequencer.sv
// tb/tb_io_input_sequencer.sv - scoreboard bench for io_input_sequencer (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64)
module tb_io_input_sequencer;

  localparam int DEB = 4;
  localparam int SW  = 13;
  localparam int TO  = 64;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          OpIn = 1'b0;
  logic          OpOut = 1'b0;
  logic [31:0]   DadosSaida = '0;
  logic [SW-1:0] Switches = '0;
  logic          Set = 1'b1;
  logic          HaltCPU;
  logic [31:0]   DataIO;
  logic          DataValid;
  logic [31:0]   OutputData;
  logic          WaitingLed;
  logic          TimeoutFlag;

  io_input_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .SW_WIDTH       (SW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .OpIn       (OpIn),
    .OpOut      (OpOut),
    .DadosSaida (DadosSaida),
    .Switches   (Switches),
    .Set        (Set),
    .HaltCPU    (HaltCPU),
    .DataIO     (DataIO),
    .DataValid  (DataValid),
    .OutputData (OutputData),
    .WaitingLed (WaitingLed),
    .TimeoutFlag(TimeoutFlag)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_exp_valid = 0;
  logic [31:0] exp_q[$];
  logic        exp_to_q[$];
  logic [31:0] out_model = '0;
  logic        to_model = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic set_low(input int n);
    Set = 1'b0;
    tick(n);
  endtask

  task automatic set_high(input int n);
    Set = 1'b1;
    tick(n);
  endtask

  task automatic start_in();
    OpIn = 1'b1;
    tick(1);
    OpIn = 1'b0;
  endtask

  task automatic expect_in(input logic [SW-1:0] sw, input logic timed_out);
    if (timed_out) to_model = 1'b1;
    exp_q.push_back({{(32-SW){1'b0}}, sw});
    exp_to_q.push_back(to_model);
    n_exp_valid++;
  endtask

  task automatic do_out(input logic [31:0] v, input logic busy);
    DadosSaida = v;
    OpOut = 1'b1;
    tick(1);
    OpOut = 1'b0;
    if (!busy) out_model = v;
    check(busy ? "out_ignored" : "out_write", OutputData, out_model);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      exp_to_q.delete();
    end
  endtask

  // Monitor: every DataValid pulse must match the oldest expected capture.
  always @(negedge Clock) begin
    if (Reset && DataValid) begin
      n_valid++;
      check("halt_at_valid", {31'd0, HaltCPU}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got DataIO %h expected no pulse", DataIO);
      end else begin
        check("data_io", DataIO, exp_q.pop_front());
        check("timeout_flag", {31'd0, TimeoutFlag}, {31'd0, exp_to_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [SW-1:0] sw;
    logic [31:0]   v;
    int            op;
    int            h;

    tick(3);
    check("rst_halt", {31'd0, HaltCPU}, 32'd0);
    check("rst_dataio", DataIO, 32'd0);
    check("rst_valid", {31'd0, DataValid}, 32'd0);
    check("rst_outdata", OutputData, 32'd0);
    check("rst_led", {31'd0, WaitingLed}, 32'd0);
    check("rst_tflag", {31'd0, TimeoutFlag}, 32'd0);
    Reset = 1'b1;
    tick(2);

    do_out(32'hDEADBEEF, 1'b0);
    check("out_no_halt", {31'd0, HaltCPU}, 32'd0);

    Switches = 13'h1ABC;
    start_in();
    check("in_halt", {31'd0, HaltCPU}, 32'd1);
    check("in_led", {31'd0, WaitingLed}, 32'd1);
    expect_in(13'h1ABC, 1'b0);
    set_low(6);
    set_high(2);
    check("wrel_halt", {31'd0, HaltCPU}, 32'd1);
    check("wrel_led", {31'd0, WaitingLed}, 32'd0);
    tick(4);
    drain(20);
    check("done_unhalt", {31'd0, HaltCPU}, 32'd0);

    Switches = 13'h0F00;
    DadosSaida = 32'hCAFEF00D;
    OpIn = 1'b1;
    OpOut = 1'b1;
    tick(1);
    OpIn = 1'b0;
    OpOut = 1'b0;
    out_model = 32'hCAFEF00D;
    check("simul_out", OutputData, out_model);
    check("simul_halt", {31'd0, HaltCPU}, 32'd1);
    do_out(32'h12345678, 1'b1);
    set_low(2);
    set_high(8);
    check("glitch_led", {31'd0, WaitingLed}, 32'd1);
    check("glitch_halt", {31'd0, HaltCPU}, 32'd1);
    Switches = 13'h0555;
    expect_in(13'h0555, 1'b0);
    set_low(6);
    set_high(8);
    drain(30);

    Switches = 13'h1FFF;
    set_low(10);
    start_in();
    tick(8);
    check("held_led", {31'd0, WaitingLed}, 32'd1);
    set_high(8);
    check("held_rel_led", {31'd0, WaitingLed}, 32'd1);
    Switches = 13'h0F0F;
    expect_in(13'h0F0F, 1'b0);
    set_low(6);
    set_high(8);
    drain(30);

    for (int it = 0; it < 12; it++) begin
      op = int'($urandom_range(0, 2));
      v = $urandom;
      if (op == 0) begin
        do_out(v, 1'b0);
      end else begin
        Switches = SW'($urandom);
        if (op == 2) begin
          DadosSaida = v;
          OpIn = 1'b1;
          OpOut = 1'b1;
          tick(1);
          OpIn = 1'b0;
          OpOut = 1'b0;
          out_model = v;
          check("rnd_simul_out", OutputData, out_model);
        end else begin
          start_in();
          do_out($urandom, 1'b1);
        end
        for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
          set_low(int'($urandom_range(1, DEB - 2)));
          set_high(int'($urandom_range(DEB + 1, DEB + 3)));
        end
        check("rnd_wait_led", {31'd0, WaitingLed}, 32'd1);
        sw = SW'($urandom);
        Switches = sw;
        expect_in(sw, 1'b0);
        set_low(int'($urandom_range(DEB + 2, DEB + 5)));
        set_high(int'($urandom_range(DEB + 2, DEB + 5)));
        drain(40);
      end
    end

    Switches = 13'h0AAA;
    start_in();
    set_low(8);
    check("mid_led", {31'd0, WaitingLed}, 32'd0);
    check("mid_dataio", DataIO, 32'h00000AAA);
    #2;
    Reset = 1'b0;
    #1;
    check("async_halt", {31'd0, HaltCPU}, 32'd0);
    check("async_dataio", DataIO, 32'd0);
    check("async_outdata", OutputData, 32'd0);
    out_model = '0;
    to_model = 1'b0;
    tick(2);
    Reset = 1'b1;
    set_high(20);
    check("post_rst_halt", {31'd0, HaltCPU}, 32'd0);

`ifdef IO_TIMEOUT_EN
    Switches = 13'h1234;
    expect_in(13'h1234, 1'b1);
    start_in();
    h = 1;
    while (HaltCPU && h < 200) begin
      tick(1);
      if (HaltCPU) h++;
    end
    check("timeout_halt_cycles", h, TO);
    drain(10);
    tick(5);
    check("timeout_sticky", {31'd0, TimeoutFlag}, 32'd1);
`else
    Switches = 13'h1234;
    start_in();
    h = 0;
    repeat (TO + 20) begin
      tick(1);
      if (HaltCPU) h++;
    end
    check("no_timeout_halt_cycles", h, TO + 20);
    check("no_timeout_flag", {31'd0, TimeoutFlag}, 32'd0);
    expect_in(13'h1234, 1'b0);
    set_low(6);
    set_high(8);
    drain(30);
`endif

    tick(3);
    check("valid_count", n_valid, n_exp_valid);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
